// File: rtl/tpu_c_drain_if.sv
// Purpose: bundles the drain-stage control, C buffer port and response stream into one port.
// Latency: none (wiring only).
// Backpressure: rsp_valid/rsp_ready handshake. The master is the drain engine; the slave side
//   is the environment (TPU control, C buffer, CFU response consumer).
// Signals: start/tpu_busy/M/N (request), busy/done (status), C_wr_en/C_index/C_data_in/
//   C_data_out (C buffer port), rsp_valid/rsp_ready/rsp_data (32-bit result stream).
interface tpu_c_drain_if #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 32,
    parameter int DATAC_BITS = 128
);
    logic                  start;
    logic                  tpu_busy;
    logic [31:0]           M;
    logic [31:0]           N;
    logic                  busy;
    logic                  done;
    logic                  C_wr_en;
    logic [ADDR_BITS-1:0]  C_index;
    logic [DATAC_BITS-1:0] C_data_in;
    logic [DATAC_BITS-1:0] C_data_out;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_BITS-1:0]  rsp_data;

    modport master (
        input  start, tpu_busy, M, N, C_data_out, rsp_ready,
        output busy, done, C_wr_en, C_index, C_data_in, rsp_valid, rsp_data
    );

    modport slave (
        output start, tpu_busy, M, N, C_data_out, rsp_ready,
        input  busy, done, C_wr_en, C_index, C_data_in, rsp_valid, rsp_data
    );
endinterface

// File: rtl/tpu_c_drain.sv
// Purpose: drains result buffer C (LANES x DATA_BITS per entry) into a DATA_BITS response stream, N words per row.
// Latency: start edge -> first rsp_valid after 2 more edges (3 with clear); per entry 2 + lanes cycles (+1 with clear).
// Backpressure: lane advances only on rsp_valid && rsp_ready; rsp_data held stable while stalled.
// Ports: clk, rst_n (async active-low); bus (tpu_c_drain_if.master): start/tpu_busy/M/N in,
//   busy/done out, C_wr_en/C_index/C_data_in out, C_data_out in, rsp_valid/rsp_data out, rsp_ready in.
// Optional: define TPU_DRAIN_CLEAR_EN to zero each C entry right after it is read (extra CLEAR cycle).
module tpu_c_drain #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 32,
    parameter int DATAC_BITS = 128
) (
    input logic           clk,
    input logic           rst_n,
    tpu_c_drain_if.master bus
);
    localparam int LANES     = DATAC_BITS / DATA_BITS;
    localparam int LANE_BITS = $clog2(LANES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CLEAR,
        S_EMIT
    } state_t;

    state_t                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_BITS-1:0]  index_q;
    logic [DATAC_BITS-1:0] hold_q;
    logic [LANE_BITS-1:0]  lane_q;
    logic                  rsp_valid_q;
    logic [DATA_BITS-1:0]  rsp_data_q;
    logic [15:0]           m_q;
    logic [15:0]           tiles_q;
    logic [15:0]           row_q;
    logic [15:0]           tile_q;
    logic [LANE_BITS-1:0]  last_lane_q;   // lane index of the final lane in the last tile of a row

    // Geometry of the request presented with start; only the low 16 bits of M/N are meaningful.
    logic [15:0]          m_in;
    logic [15:0]          n_in;
    logic [16:0]          n_round;
    logic [15:0]          tiles_in;
    logic [LANE_BITS-1:0] last_lane_in;

    assign m_in         = bus.M[15:0];
    assign n_in         = bus.N[15:0];
    assign n_round      = {1'b0, n_in} + 17'(LANES - 1);      // 17 bits so N=0xFFFF does not wrap
    assign tiles_in     = 16'(n_round >> LANE_BITS);
    assign last_lane_in = LANE_BITS'(n_in - 16'd1);            // padded lanes dropped in last tile

    // Per-entry bookkeeping used in EMIT.
    logic                 last_tile;
    logic                 last_entry;
    logic [LANE_BITS-1:0] last_lane_now;
    logic [LANE_BITS-1:0] lane_nxt;
    logic [DATA_BITS-1:0] next_word;

    always_comb begin
        last_tile     = (tile_q == tiles_q - 16'd1);
        last_entry    = last_tile && (row_q == m_q - 16'd1);
        last_lane_now = last_tile ? last_lane_q : LANE_BITS'(LANES - 1);
        lane_nxt      = lane_q + 1'b1;
        next_word     = hold_q[lane_nxt*DATA_BITS +: DATA_BITS];
    end

`ifdef TPU_DRAIN_CLEAR_EN
    logic wr_en_q;
    assign bus.C_wr_en = wr_en_q;
`else
    assign bus.C_wr_en = 1'b0;
`endif
    assign bus.C_data_in = '0;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.C_index   = index_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            index_q     <= '0;
            hold_q      <= '0;
            lane_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            m_q         <= '0;
            tiles_q     <= '0;
            row_q       <= '0;
            tile_q      <= '0;
            last_lane_q <= '0;
`ifdef TPU_DRAIN_CLEAR_EN
            wr_en_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.tpu_busy) begin
                        if (m_in == 16'd0 || n_in == 16'd0) begin
                            // Empty result: acknowledge without touching C.
                            done_q <= 1'b1;
                        end else begin
                            m_q         <= m_in;
                            tiles_q     <= tiles_in;
                            last_lane_q <= last_lane_in;
                            row_q       <= '0;
                            tile_q      <= '0;
                            index_q     <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    // C_index is already driven; read data lands during WAIT.
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    hold_q <= bus.C_data_out;
                    lane_q <= '0;
`ifdef TPU_DRAIN_CLEAR_EN
                    wr_en_q <= 1'b1;
                    state_q <= S_CLEAR;
`else
                    rsp_data_q  <= bus.C_data_out[DATA_BITS-1:0];
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_EMIT;
`endif
                end

                S_CLEAR: begin
`ifdef TPU_DRAIN_CLEAR_EN
                    wr_en_q <= 1'b0;
`endif
                    rsp_data_q  <= hold_q[DATA_BITS-1:0];
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_EMIT;
                end

                S_EMIT: begin
                    if (bus.rsp_ready) begin
                        if (lane_q == last_lane_now) begin
                            rsp_valid_q <= 1'b0;
                            if (last_entry) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                // Entries are laid out row-major, so the address just counts up.
                                index_q <= index_q + 1'b1;
                                if (last_tile) begin
                                    tile_q <= '0;
                                    row_q  <= row_q + 16'd1;
                                end else begin
                                    tile_q <= tile_q + 16'd1;
                                end
                                state_q <= S_FETCH;
                            end
                        end else begin
                            lane_q     <= lane_nxt;
                            rsp_data_q <= next_word;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_c_drain.sv
module tb_tpu_c_drain;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

`ifdef TPU_DRAIN_CLEAR_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    tpu_c_drain_if bus ();

    tpu_c_drain dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // C buffer model: registered read, one write port shared with a bench preload path.
    logic [127:0] mem [0:15];
    logic         pre_en = 1'b0;
    logic [3:0]   pre_idx = '0;
    logic [127:0] pre_dat = '0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_dat;
        else if (bus.C_wr_en) mem[bus.C_index[3:0]] <= bus.C_data_in;
        bus.C_data_out <= mem[bus.C_index[3:0]];
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    int          idx_q[$];
    int          wr_q[$];
    logic        prev_vld = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [31:0] prev_dat = '0;
    int          popped   = 0;
    logic        pat [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

    function automatic logic [31:0] lane_val(int e, int l);
        return 32'(e * 256 + l + 1);
    endfunction

    task automatic reload_mem();
        for (int e = 0; e < 16; e++) begin
            pre_en  = 1'b1;
            pre_idx = 4'(e);
            pre_dat = {lane_val(e, 3), lane_val(e, 2), lane_val(e, 1), lane_val(e, 0)};
            @(posedge clk); #1;
        end
        pre_en = 1'b0;
    endtask

    // Scoreboard: queue words, fetch indices and clear writes for an M x N drain; return cycle count at rsp_ready=1.
    task automatic push_expected(input int m, input int n, output int cycles);
        int tiles, e, lanes;
        tiles  = (n + 3) / 4;
        cycles = 0;
        for (int r = 0; r < m; r++) begin
            for (int t = 0; t < tiles; t++) begin
                e     = r * tiles + t;
                lanes = (t == tiles - 1) ? (n - 4 * (tiles - 1)) : 4;
                idx_q.push_back(e);
                wr_q.push_back(e);
                for (int l = 0; l < lanes; l++) exp_q.push_back(lane_val(e, l));
                cycles += 2 + EXTRA + lanes;
            end
        end
    endtask

    // One negedge sample of the DUT outputs with all stream checks.
    task automatic sample_cycle();
        int          e;
        logic [31:0] w;
        @(negedge clk);
        if (prev_vld && !prev_rdy) begin
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== prev_dat) begin
                n_fail++;
                $display("FAIL hold_stall: valid=%b data=%h, required valid=1 data=%h", bus.rsp_valid, bus.rsp_data, prev_dat);
            end
        end
        if (bus.rsp_valid && !prev_vld) begin
            n_checks++;
            if (idx_q.size() == 0) begin
                n_fail++;
                $display("FAIL entry_index: unexpected entry at C_index=%0d, required none", bus.C_index);
            end else begin
                e = idx_q.pop_front();
                if (bus.C_index !== 16'(e)) begin
                    n_fail++;
                    $display("FAIL entry_index: C_index=%0d, required %0d", bus.C_index, e);
                end
            end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            n_checks++;
            popped++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_word: unexpected word %h, required none", bus.rsp_data);
            end else begin
                w = exp_q.pop_front();
                if (bus.rsp_data !== w) begin
                    n_fail++;
                    $display("FAIL rsp_word: got %h, required %h", bus.rsp_data, w);
                end
            end
        end
        if (bus.C_wr_en) begin
            n_checks++;
`ifdef TPU_DRAIN_CLEAR_EN
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL clear_write: unexpected write at %0d, required none", bus.C_index);
            end else begin
                e = wr_q.pop_front();
                if (bus.C_index !== 16'(e) || bus.C_data_in !== 128'd0) begin
                    n_fail++;
                    $display("FAIL clear_write: index=%0d data=%h, required index=%0d data=0", bus.C_index, bus.C_data_in, e);
                end
            end
`else
            n_fail++;
            $display("FAIL no_write: C_wr_en=1, required 0");
`endif
        end
        prev_vld = bus.rsp_valid;
        prev_rdy = bus.rsp_ready;
        prev_dat = bus.rsp_data;
    endtask

    task automatic do_start(input int m, input int n);
        sample_cycle();
        bus.M     = 32'(m);
        bus.N     = 32'(n);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Sample until done; mode 0 keeps rsp_ready high, mode 1 toggles it 1,0,0,1.
    task automatic run_drain(input int budget, input int mode, input bit extra_start,
                             output int done_cyc, output int first_vld);
        done_cyc  = -1;
        first_vld = -1;
        for (int k = 0; k < budget; k++) begin
            sample_cycle();
            if (first_vld < 0 && bus.rsp_valid) first_vld = k;
            if (bus.done) begin
                done_cyc = k;
                n_checks++;
                if (bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_at_done: busy=%b, required 0", bus.busy);
                end
                break;
            end
            @(posedge clk); #1;
            bus.rsp_ready = (mode == 0) ? 1'b1 : pat[(k + 1) % 4];
            if (extra_start) begin
                bus.start = (k == 2);
                bus.M     = 32'd2;
                bus.N     = 32'd8;
            end
        end
        bus.start     = 1'b0;
        bus.rsp_ready = 1'b1;
        n_checks++;
        if (done_cyc < 0) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles, required done", budget);
        end else begin
            sample_cycle();
            if (bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse: done=%b one cycle later, required 0", bus.done);
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || idx_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_complete: %0d words %0d entries left, required 0", exp_q.size(), idx_q.size());
        end
        wr_q.delete();
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.tpu_busy = 1'b0; bus.M = '0; bus.N = '0; bus.rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.C_wr_en, bus.rsp_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/wr/valid=%b, required 0000", {bus.busy, bus.done, bus.C_wr_en, bus.rsp_valid});
        end
        n_checks++;
        if (bus.C_index !== 16'd0 || bus.C_data_in !== 128'd0 || bus.rsp_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: index=%h data_in=%h rsp_data=%h, required 0", bus.C_index, bus.C_data_in, bus.rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_entry();
        int cyc, dc, fv;
        reload_mem();
        push_expected(1, 4, cyc);
        do_start(1, 4);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.C_index !== 16'd0 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_cycle: busy=%b index=%0d valid=%b, required 1 0 0", bus.busy, bus.C_index, bus.rsp_valid);
        end
        run_drain(100, 0, 1'b0, dc, fv);
        n_checks++;
        if (fv !== 2 + EXTRA) begin
            n_fail++;
            $display("FAIL first_valid: cycle %0d, required %0d", fv, 2 + EXTRA);
        end
        n_checks++;
        if (dc !== cyc) begin
            n_fail++;
            $display("FAIL done_latency: cycle %0d, required %0d", dc, cyc);
        end
    endtask

    task automatic test_shapes();
        int ms [3] = '{2, 3, 1};
        int ns [3] = '{6, 5, 3};
        int cyc, dc, fv;
        for (int i = 0; i < 3; i++) begin
            reload_mem();
            push_expected(ms[i], ns[i], cyc);
            do_start(ms[i], ns[i]);
            run_drain(300, 0, 1'b0, dc, fv);
            n_checks++;
            if (dc !== cyc) begin
                n_fail++;
                $display("FAIL shape_latency M=%0d N=%0d: cycle %0d, required %0d", ms[i], ns[i], dc, cyc);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc, dc, fv;
        logic any_busy;
        reload_mem();
        push_expected(1, 4, cyc);
        do_start(1, 4);
        run_drain(200, 1, 1'b1, dc, fv);
        any_busy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sample_cycle();
            if (bus.busy || bus.rsp_valid) any_busy = 1'b1;
        end
        n_checks++;
        if (any_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_while_busy: activity after done=%b, required 0", any_busy);
        end
    endtask

    task automatic test_ignored_starts();
        int cyc, dc, fv;
        logic [15:0] idx0;
        logic any_act;
        idx0 = bus.C_index;
        push_expected(0, 8, cyc);
        do_start(0, 8);
        run_drain(10, 0, 1'b0, dc, fv);
        n_checks++;
        if (dc !== 0 || bus.C_index !== idx0) begin
            n_fail++;
            $display("FAIL empty_M: done cycle %0d index=%0d, required 0 %0d", dc, bus.C_index, idx0);
        end
        do_start(3, 0);
        run_drain(10, 0, 1'b0, dc, fv);
        n_checks++;
        if (dc !== 0 || bus.C_index !== idx0) begin
            n_fail++;
            $display("FAIL empty_N: done cycle %0d index=%0d, required 0 %0d", dc, bus.C_index, idx0);
        end
        bus.tpu_busy = 1'b1;
        do_start(1, 4);
        any_act = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sample_cycle();
            if (bus.busy || bus.done || bus.rsp_valid) any_act = 1'b1;
        end
        bus.tpu_busy = 1'b0;
        n_checks++;
        if (any_act !== 1'b0) begin
            n_fail++;
            $display("FAIL tpu_busy_start: activity=%b, required 0", any_act);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, dc, fv;
        reload_mem();
        push_expected(1, 4, cyc);
        do_start(1, 4);
        popped = 0;
        for (int k = 0; k < 20 && popped < 2; k++) sample_cycle();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.busy, bus.done} !== 3'b000 || bus.C_index !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid: valid/busy/done=%b index=%0d, required 000 0", {bus.rsp_valid, bus.busy, bus.done}, bus.C_index);
        end
        exp_q.delete(); idx_q.delete(); wr_q.delete();
        prev_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        reload_mem();
        push_expected(1, 4, cyc);
        do_start(1, 4);
        run_drain(100, 0, 1'b0, dc, fv);
        n_checks++;
        if (dc !== cyc) begin
            n_fail++;
            $display("FAIL restart_latency: cycle %0d, required %0d", dc, cyc);
        end
    endtask

`ifdef TPU_DRAIN_CLEAR_EN
    task automatic test_clear();
        int cyc, dc, fv;
        reload_mem();
        push_expected(2, 4, cyc);
        do_start(2, 4);
        run_drain(100, 0, 1'b0, dc, fv);
        n_checks++;
        if (dc !== cyc || fv !== 3) begin
            n_fail++;
            $display("FAIL clear_timing: done %0d first_valid %0d, required %0d 3", dc, fv, cyc);
        end
        n_checks++;
        if (mem[0] !== 128'd0 || mem[1] !== 128'd0) begin
            n_fail++;
            $display("FAIL clear_readback: C0=%h C1=%h, required 0", mem[0], mem[1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_entry();
        test_shapes();
        test_backpressure();
        test_ignored_starts();
        test_reset_mid();
`ifdef TPU_DRAIN_CLEAR_EN
        test_clear();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
